// File: rtl/tri_input_stabilizer_pkg.sv
// Shared types and constants for the three-input stabilizer front-end.
// Bit positions follow the downstream gate's {in1,in2,in3} case ordering.
package tri_stab_pkg;

    localparam int VEC_W   = 3;
    localparam int IDX_IN1 = 2;
    localparam int IDX_IN2 = 1;
    localparam int IDX_IN3 = 0;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/tri_input_stabilizer_if.sv
// Valid/ready handshake bundle between the stabilizer and the 3-input gate.
// The master modport is the stabilizer side; the slave modport is the consumer side.
interface tri_stab_if;
    import tri_stab_pkg::*;

    logic [VEC_W-1:0] vec_o;
    logic             vec_valid;
    logic             vec_ready;
    logic             overflow;

    modport master (output vec_o, output vec_valid, output overflow, input vec_ready);
    modport slave  (input vec_o, input vec_valid, input overflow, output vec_ready);
endinterface

// File: rtl/tri_input_stabilizer_bit_sync.sv
// Multi-flop synchronizer for one raw asynchronous line.
// The first stage is the only flop that may go metastable; q is taken from the last stage.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the raw sample through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= '0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/tri_input_stabilizer.sv
// Synchronizes and debounces three raw lines as one vector and hands only
// stable, changed vectors to the downstream gate over valid/ready.
module tri_input_stabilizer
    import tri_stab_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    tri_stab_if.master bus
);

    logic [VEC_W-1:0] sync_s;
    logic [VEC_W-1:0] cand_r;
    logic [CNT_W-1:0] cnt_r;
    logic [VEC_W-1:0] last_seen_r;
    logic [VEC_W-1:0] vec_r;
    logic [VEC_W-1:0] pend_r;
    logic             pend_full_r;
    logic             overflow_r;
    state_t           state_r;

    logic             stable_evt_s;
    logic             qual_evt_s;
    logic             accept_s;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_in1 (.clk(clk), .rst_n(rst_n), .d(in1), .q(sync_s[IDX_IN1]));
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_in2 (.clk(clk), .rst_n(rst_n), .d(in2), .q(sync_s[IDX_IN2]));
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_in3 (.clk(clk), .rst_n(rst_n), .d(in3), .q(sync_s[IDX_IN3]));

    // Saturation means the STABLE_CYCLES-1 value is crossed once per candidate.
    assign stable_evt_s = (sync_s == cand_r) && (cnt_r == CNT_W'(STABLE_CYCLES - 1));
    assign qual_evt_s   = stable_evt_s && (cand_r != last_seen_r);
    assign accept_s     = (state_r == ST_PRESENT) && bus.vec_ready;

    // Candidate tracking and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_r <= {VEC_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else if (sync_s != cand_r) begin
            cand_r <= sync_s;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (cnt_r != CNT_W'(STABLE_CYCLES)) begin
            cnt_r  <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r  <= cnt_r;
        end
    end

    // Most recent qualifying vector; reset value 000 is treated as already committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_seen_r <= {VEC_W{1'b0}};
        end else if (qual_evt_s) begin
            last_seen_r <= cand_r;
        end else begin
            last_seen_r <= last_seen_r;
        end
    end

    // Handshake FSM with output register, single-entry pending slot and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            vec_r       <= {VEC_W{1'b0}};
            pend_r      <= {VEC_W{1'b0}};
            pend_full_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (qual_evt_s) begin
                        vec_r   <= cand_r;
                        state_r <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (accept_s) begin
                        // A fresh event on the accept cycle supersedes anything queued.
                        if (qual_evt_s) begin
                            vec_r       <= cand_r;
                            pend_full_r <= 1'b0;
                        end else if (pend_full_r) begin
                            vec_r       <= pend_r;
                            pend_full_r <= 1'b0;
                        end else begin
                            state_r     <= ST_IDLE;
                        end
                    end else if (qual_evt_s) begin
                        pend_r      <= cand_r;
                        pend_full_r <= 1'b1;
                        if (pend_full_r) begin
                            overflow_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    pend_full_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec_o     = vec_r;
    assign bus.vec_valid = (state_r == ST_PRESENT);
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_tri_input_stabilizer.sv
// Directed bench: accepted vectors are checked by a scoreboard monitor,
// cycle-exact conditions (latency, hold, overflow, reset) by direct checks.
module tb_tri_input_stabilizer;

    logic clk;
    logic rst_n;
    logic in1, in2, in3;

    tri_stab_if bus ();

    tri_input_stabilizer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in1  (in1),
        .in2  (in2),
        .in3  (in3),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic set_in(input logic [2:0] v);
        {in1, in2, in3} = v;
    endtask

    // Advance n rising edges, then settle 2 time units past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: every accepted handshake must match the next expected vector.
    always @(negedge clk) begin
        if (rst_n && bus.vec_valid && bus.vec_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %03b expected nothing at %0t", bus.vec_o, $time);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (bus.vec_o !== e) begin
                    n_err++;
                    $display("FAIL sb_vec: got %03b expected %03b at %0t", bus.vec_o, e, $time);
                end
            end
        end
    end

    initial begin
        int vcnt;
        rst_n = 1'b0;
        bus.vec_ready = 1'b0;
        set_in(3'b101);

        // Reset state with inputs held at 101.
        step(3);
        check("rst_vec", {5'b0, bus.vec_o}, 8'h00);
        check("rst_valid", {7'b0, bus.vec_valid}, 8'h00);
        check("rst_ovf", {7'b0, bus.overflow}, 8'h00);

        // Latency: vec_valid rises exactly at the 7th edge after release.
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step(1);
            if (e == 6) check("lat_not_early", {7'b0, bus.vec_valid}, 8'h00);
        end
        check("lat_valid", {7'b0, bus.vec_valid}, 8'h01);
        check("lat_vec", {5'b0, bus.vec_o}, 8'h05);
        exp_q.push_back(3'b101);
        bus.vec_ready = 1'b1;
        step(1);
        check("accept_drop", {7'b0, bus.vec_valid}, 8'h00);

        // Glitch: commit 001, then a 2-cycle pulse on in2 must be ignored.
        exp_q.push_back(3'b001);
        set_in(3'b001);
        step(12);
        set_in(3'b011);
        step(2);
        set_in(3'b001);
        vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (bus.vec_valid) vcnt++;
        end
        check("glitch_no_valid", vcnt[7:0], 8'h00);
        check("glitch_vec_hold", {5'b0, bus.vec_o}, 8'h01);

        // Backpressure with one pending entry.
        bus.vec_ready = 1'b0;
        set_in(3'b010);
        step(8);
        check("bp_first", {5'b0, bus.vec_o}, 8'h02);
        set_in(3'b100);
        step(8);
        check("bp_hold", {5'b0, bus.vec_o}, 8'h02);
        check("bp_valid", {7'b0, bus.vec_valid}, 8'h01);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        bus.vec_ready = 1'b1;
        step(1);
        bus.vec_ready = 1'b0;
        check("bp_pend_vec", {5'b0, bus.vec_o}, 8'h04);
        check("bp_pend_valid", {7'b0, bus.vec_valid}, 8'h01);
        bus.vec_ready = 1'b1;
        step(1);
        bus.vec_ready = 1'b0;
        check("bp_drain", {7'b0, bus.vec_valid}, 8'h00);
        check("bp_no_ovf", {7'b0, bus.overflow}, 8'h00);

        // Overflow: pending slot overwritten, latest value wins.
        set_in(3'b010);
        step(8);
        set_in(3'b100);
        step(8);
        set_in(3'b110);
        step(8);
        check("ovf_flag", {7'b0, bus.overflow}, 8'h01);
        check("ovf_hold", {5'b0, bus.vec_o}, 8'h02);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b110);
        bus.vec_ready = 1'b1;
        step(1);
        bus.vec_ready = 1'b0;
        check("ovf_latest", {5'b0, bus.vec_o}, 8'h06);
        bus.vec_ready = 1'b1;
        step(1);
        bus.vec_ready = 1'b0;
        check("ovf_drain", {7'b0, bus.vec_valid}, 8'h00);
        check("ovf_sticky", {7'b0, bus.overflow}, 8'h01);

        // Acceptance on the exact event cycle of a new stable vector.
        set_in(3'b001);
        step(8);
        check("sim_pre", {5'b0, bus.vec_o}, 8'h01);
        set_in(3'b111);
        step(6);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b111);
        bus.vec_ready = 1'b1;
        step(1);
        check("sim_vec", {5'b0, bus.vec_o}, 8'h07);
        check("sim_valid", {7'b0, bus.vec_valid}, 8'h01);
        step(1);
        check("sim_pend_empty", {7'b0, bus.vec_valid}, 8'h00);
        step(2);
        bus.vec_ready = 1'b0;

        // Asynchronous reset while presenting with pending full and overflow set.
        set_in(3'b010);
        step(8);
        set_in(3'b100);
        step(8);
        set_in(3'b000);
        step(8);
        check("mid_pre_valid", {7'b0, bus.vec_valid}, 8'h01);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_vec", {5'b0, bus.vec_o}, 8'h00);
        check("mid_rst_valid", {7'b0, bus.vec_valid}, 8'h00);
        check("mid_rst_ovf", {7'b0, bus.overflow}, 8'h00);
        step(2);
        rst_n = 1'b1;
        step(12);
        check("post_rst_idle", {7'b0, bus.vec_valid}, 8'h00);
        check("sb_drained", exp_q.size() > 0 ? 8'h01 : 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tri_input_stabilizer.md
Name: tri_input_stabilizer

Overview:
- Upstream front-end for the 3-input combinational gate stages. Takes three asynchronous raw inducer/sensor lines, synchronizes them, and debounces them as one 3-bit vector.
- Presents only stable vectors to the downstream gate through a valid/ready handshake.
- Ensures the gate never evaluates transient input combinations, such as a glitch through 3'b011 while moving from 3'b001 to 3'b111.

Parameters:
- SYNC_STAGES, 2, flip-flop stages per raw input synchronizer (minimum 2).
- STABLE_CYCLES, 4, consecutive identical synced samples required before a vector is stable (minimum 1).
- CNT_W, 8, stability counter width. Must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  single system clock
- rst_n  input  1  asynchronous active-low reset
- in1  input  1  raw input 1, asynchronous to clk
- in2  input  1  raw input 2, asynchronous to clk
- in3  input  1  raw input 3, asynchronous to clk
- vec_o  output  3  committed vector {in1,in2,in3}; in1 is the MSB, matching the downstream case ordering
- vec_valid  output  1  vec_o holds a new stable vector not yet accepted
- vec_ready  input  1  downstream accepts vec_o on a cycle where vec_valid && vec_ready
- overflow  output  1  sticky flag: a pending stable vector was overwritten before it could be presented

Behaviour:
- Reset: async assert, sync deassert handled externally.
  - Asserting rst_n=0 mid-operation immediately clears every register.
  - Reset values: synchronizers 0, cand=3'b000, cnt=0, committed=3'b000, pending empty, vec_o=3'b000, vec_valid=0, overflow=0.
  - The reset vector 3'b000 counts as already committed; it is never presented.
- Sync: each raw line passes through its own SYNC_STAGES-flop chain, giving sync[2:0]. No other logic touches the raw inputs.
- Stability tracking, evaluated every cycle:
  - If sync != cand: cand <= sync, cnt <= 0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
  - A stable event fires on the cycle cnt transitions from STABLE_CYCLES-1 to STABLE_CYCLES. It fires once per candidate.
  - The event is qualifying only if cand != last_seen, where last_seen is the most recent qualifying vector (presented or pending). On a qualifying event, last_seen <= cand.
- Handshake FSM, two states:
  - IDLE: vec_valid=0. A qualifying event loads vec_o <= cand and moves to PRESENT, with vec_valid=1 from the next cycle.
  - PRESENT: vec_valid=1 and vec_o is held constant until accepted.
    - A qualifying event while in PRESENT without acceptance stores cand in a single-entry pending slot.
    - If pending was already full, the new value overwrites it (latest wins) and overflow <= 1.
  - Acceptance (vec_valid && vec_ready):
    - Pending full: vec_o <= pending, pending cleared, stay in PRESENT.
    - Pending empty: go to IDLE, vec_valid=0 next cycle.
    - Acceptance and a qualifying event in the same cycle: the event value goes straight to vec_o, stay PRESENT, pending unchanged and empty. The previous vec_o counts as consumed.
- Latency: a clean step held constant raises vec_valid SYNC_STAGES + STABLE_CYCLES + 1 rising edges after the first edge that samples it. With defaults this is 7.
- Glitch rejection: a synced change that reverts within fewer than STABLE_CYCLES cycles produces no event, and vec_o/vec_valid are unaffected.
- A vector returning to the value already in last_seen produces no event. Example: 001 → 011 (glitch, rejected) → 001 gives no output.
- overflow clears only on reset.
- vec_o changes only on acceptance or on an IDLE→PRESENT load.

Decomposition:
- Shared package tri_stab_pkg:
  - state enum {ST_IDLE, ST_PRESENT}
  - localparam VEC_W=3
  - bit-index constants IDX_IN1=2, IDX_IN2=1, IDX_IN3=0
- One sub-module: bit_sync (parameter STAGES, ports clk, rst_n, d, q), instantiated three times.
- Counter, pending slot and FSM stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with inputs 3'b101 → vec_o=000, vec_valid=0, overflow=0. Release and hold 101 → vec_valid=1 with vec_o=3'b101 at edge 7; vec_ready=1 → vec_valid=0 next cycle.
- Glitch: steady 001 committed and accepted; in2 pulses high for 2 clk (synced 011 for 2 cycles) → no vec_valid, vec_o stays 001.
- Backpressure/pending: vec_ready=0; stable 010 presented, then stable 100 → vec_o stays 010, pending=100. Pulse vec_ready → vec_o=100 next cycle, vec_valid remains 1. Pulse again → vec_valid=0.
- Overflow: vec_ready=0; stable 010 presented, then stable 100, then stable 110 → overflow=1. After one accept, vec_o=110.
- Simultaneous: vec_valid=1 (vec_o=001) with vec_ready=1 on the exact event cycle of stable 111 → vec_o=111 next cycle, vec_valid stays 1, pending empty.
- Reset mid-operation: assert rst_n=0 asynchronously (between edges) while in PRESENT with pending full and overflow=1 → all outputs return to reset values without waiting for a clk edge.
